ddr5_refresh_executor: RTL and testbench
========================================

# ddr5_refresh_executor

Responder side of the refresh request handshake: accepts refresh requests (all-bank, per-bank, same-bank, FGR tick) from the refresh generator and turns them into DDR5 command sequences on the scheduler's command port. For each request it blocks the target rank, precharges it if banks are open, issues the REF, and holds the rank blocked for tRFC. Sits between the refresh generator and the command arbiter in the controller core.

## Interface
- NUM_RANKS, 2, ranks served; block_rank/sched_pending/rank_banks_open width
- tRP, 30, PREab-to-REF cycles
- tRFC_AB, 350, REFab busy cycles
- tRFC_PB, 160, REFpb busy cycles
- tRFC_SB, 120, REFsb busy cycles
- MAX_POSTPONE, 4, max postponed REFab per rank (macro only)

- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- ref_req_valid  in  1  request valid
- ref_req_ready  out  1  request accepted when valid&ready
- ref_type  in  2  0 AB, 1 PB, 2 SB, 3 FGR tick
- ref_bank  in  5  bank for PB/SB
- ref_bg  in  3  bank group for PB/SB
- ref_rank  in  1  target rank
- rank_banks_open  in  NUM_RANKS  any bank open in rank
- sched_pending  in  NUM_RANKS  scheduler has queued traffic for rank
- block_rank  out  NUM_RANKS  scheduler must not issue ACT/RD/WR to rank
- cmd_valid  out  1  command valid
- cmd_ready  in  1  arbiter accepts command
- cmd_op  out  2  0 PREab, 1 REFab, 2 REFpb, 3 REFsb
- cmd_rank  out  1  command rank
- cmd_bank  out  5  command bank
- cmd_bg  out  3  command bank group
- busy  out  1  state != IDLE
- cnt_ref_issued  out  32  REF commands handshaken
- cnt_fgr_dropped  out  32  FGR ticks accepted

## Operation
- States: IDLE, BLOCK, PRE, WAIT_RP, REF, TRFC. Reset: IDLE; all outputs 0, counters 0.
- IDLE: ref_req_ready=1. Accepted request latched into job register {type,rank,bank,bg}.
- FGR (type 3): accepted, no command, cnt_fgr_dropped+1, stay IDLE.
- AB/PB/SB: go BLOCK. block_rank[job.rank]=1 in every non-IDLE state.
- BLOCK (1 cycle): rank_banks_open[job.rank] ? PRE : REF. PB/SB also close all banks (PREab).
- PRE: cmd_valid=1, cmd_op=PREab; on handshake load tRP-1, go WAIT_RP.
- WAIT_RP: decrement; at 0 go REF.
- REF: cmd_valid=1, cmd_op from type; bank/bg from job (0 for AB); on handshake cnt_ref_issued+1, load tRFC_x-1, go TRFC.
- TRFC: decrement; at 0 go IDLE.
- cmd_* held stable while cmd_valid & !cmd_ready.
- Reset mid-operation: immediate IDLE, block_rank 0, cmd_valid 0, debts cleared.

## Timing
- Accept at cycle T: BLOCK T+1, first cmd_valid T+2.
- REF handshake at H: block_rank high through H+tRFC-1; ref_req_ready=1 at H+tRFC.
- PRE handshake at P: REF cmd_valid earliest P+tRP.
- No combinational path valid→ready; ref_req_ready is a function of state (and debt under the macro).
- Counters wrap at 2^32.

## Configuration
- DDR5_REF_POSTPONE_EN defined: per-rank debt counter 0..MAX_POSTPONE. AB request with sched_pending[rank]=1 and debt<MAX is accepted in IDLE, debt+1, no job. In IDLE, lowest-index rank with debt>0 and (!sched_pending or debt==MAX) starts an AB job; this has priority over new requests (ref_req_ready=0 that cycle). Debt-1 at REFab handshake. AB to a rank with debt==MAX is not accepted until its job starts.
- Not defined: no debt logic; every AB executes immediately.

## Structure
- Package ddr5_ref_pkg: ref_e (shared with generator), cmd_op_e, exec_state_e, tRFC default constants.
- Sub-module ddr5_ref_timer: loadable down-counter (16 bit) with zero flag, used for tRP and tRFC.

## Test plan
- AB rank0, banks closed, cmd_ready=1: REFab at T+2, block_rank[0] 350 cycles after handshake, ready returns H+350, cnt_ref_issued=1.
- PB bank 5 bg 2 rank1, banks open: PREab then REFpb bank5/bg2 exactly 30 cycles after PRE handshake; block 160 cycles.
- cmd_ready low 5 cycles during REF: cmd_valid/op/rank/bank stable, handshake on 6th, tRFC counted from it.
- FGR tick: accepted in one cycle, no cmd_valid, cnt_fgr_dropped=1, stays IDLE.
- Macro on, sched_pending[1]=1, 4 AB rank1: all accepted, no cmds; forced REFab issued; 5th accepted after it; sched_pending drop drains remaining debt back-to-back.
- rst_n asserted in TRFC: block_rank, busy, cmd_valid 0 immediately; next request accepted after release.

Source files
------------

// File: rtl/ddr5_ref_pkg.sv
// ddr5_ref_pkg: types and default timings shared by the refresh executor,
// its timer and the refresh generator.
//   ref_e        - refresh request kind carried on ref_type
//   cmd_op_e     - command opcode driven on cmd_op
//   exec_state_e - executor FSM state
package ddr5_ref_pkg;

   typedef enum logic [1:0] {
      RefAb  = 2'd0,
      RefPb  = 2'd1,
      RefSb  = 2'd2,
      RefFgr = 2'd3
   } ref_e;

   typedef enum logic [1:0] {
      OpPreab = 2'd0,
      OpRefab = 2'd1,
      OpRefpb = 2'd2,
      OpRefsb = 2'd3
   } cmd_op_e;

   typedef enum logic [2:0] {
      StIdle,
      StBlock,
      StPre,
      StWaitRp,
      StRef,
      StTrfc
   } exec_state_e;

   localparam int unsigned TRP_DFLT     = 30;
   localparam int unsigned TRFC_AB_DFLT = 350;
   localparam int unsigned TRFC_PB_DFLT = 160;
   localparam int unsigned TRFC_SB_DFLT = 120;

   // FGR never reaches the command port; it maps to REFab only to keep the
   // function total.
   function automatic cmd_op_e ref_to_op(ref_e t);
      unique case (t)
         RefPb:   return OpRefpb;
         RefSb:   return OpRefsb;
         default: return OpRefab;
      endcase
   endfunction

endpackage

// File: rtl/ddr5_ref_timer.sv
// ddr5_ref_timer: loadable down-counter used for the tRP and tRFC waits.
//   clk, rst_n  - clock, asynchronous active-low reset
//   load_i      - load load_val_i this cycle
//   load_val_i  - value to load
//   expire_o    - counter reaches zero at the coming edge (count <= 1)
module ddr5_ref_timer #(
   parameter int unsigned Width = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [Width-1:0] load_val_i,
   output logic             expire_o
);

   logic [Width-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - Width'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   // Looking one count ahead makes a load of N-1 span exactly N cycles
   // from the loading handshake to the following state.
   assign expire_o = (cnt_q <= Width'(1));

endmodule

// File: rtl/ddr5_refresh_executor.sv
// ddr5_refresh_executor: turns refresh requests into PREab/REF command
// sequences and blocks the target rank until tRFC has elapsed.
//   ref_req_*          - request handshake from the refresh generator
//   rank_banks_open    - per-rank "any bank open", selects the PREab path
//   sched_pending      - per-rank queued traffic (postponement only)
//   block_rank         - rank is owned by refresh, no ACT/RD/WR
//   cmd_*              - command port toward the arbiter
//   busy, cnt_*        - status and event counters (wrap at 2^32)
// Optional: DDR5_REF_POSTPONE_EN enables per-rank REFab postponement debt.
module ddr5_refresh_executor
   import ddr5_ref_pkg::*;
#(
   parameter int unsigned NUM_RANKS    = 2,
   parameter int unsigned tRP          = TRP_DFLT,
   parameter int unsigned tRFC_AB      = TRFC_AB_DFLT,
   parameter int unsigned tRFC_PB      = TRFC_PB_DFLT,
   parameter int unsigned tRFC_SB      = TRFC_SB_DFLT,
   parameter int unsigned MAX_POSTPONE = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ref_req_valid,
   output logic                 ref_req_ready,
   input  logic [1:0]           ref_type,
   input  logic [4:0]           ref_bank,
   input  logic [2:0]           ref_bg,
   input  logic                 ref_rank,
   input  logic [NUM_RANKS-1:0] rank_banks_open,
   input  logic [NUM_RANKS-1:0] sched_pending,
   output logic [NUM_RANKS-1:0] block_rank,
   output logic                 cmd_valid,
   input  logic                 cmd_ready,
   output logic [1:0]           cmd_op,
   output logic                 cmd_rank,
   output logic [4:0]           cmd_bank,
   output logic [2:0]           cmd_bg,
   output logic                 busy,
   output logic [31:0]          cnt_ref_issued,
   output logic [31:0]          cnt_fgr_dropped
);

   localparam logic [15:0] TrpLd   = 16'(tRP - 1);
   localparam logic [15:0] TrfcAb  = 16'(tRFC_AB - 1);
   localparam logic [15:0] TrfcPb  = 16'(tRFC_PB - 1);
   localparam logic [15:0] TrfcSb  = 16'(tRFC_SB - 1);

   exec_state_e state_q, state_d;
   ref_e        job_type_q, job_type_d;
   logic        job_rank_q, job_rank_d;
   logic [4:0]  job_bank_q, job_bank_d;
   logic [2:0]  job_bg_q, job_bg_d;
   logic [31:0] cnt_ref_q, cnt_ref_d;
   logic [31:0] cnt_fgr_q, cnt_fgr_d;

   logic        tmr_load, tmr_expire;
   logic [15:0] tmr_val;

   logic        force_vld;   // a debt-forced REFab takes this IDLE cycle
   logic        force_rank;
   logic        defer_req;   // current request would be postponed

`ifdef DDR5_REF_POSTPONE_EN
   localparam int unsigned DebtW = $clog2(MAX_POSTPONE + 1);
   localparam logic [DebtW-1:0] DebtMax = DebtW'(MAX_POSTPONE);

   logic [DebtW-1:0] debt_q [NUM_RANKS];
   logic [DebtW-1:0] debt_d [NUM_RANKS];
   logic             defer_acc, refab_hs;

   // Descending scan so the lowest-index eligible rank wins.
   always_comb begin
      force_vld  = 1'b0;
      force_rank = 1'b0;
      for (int r = NUM_RANKS - 1; r >= 0; r--) begin
         if (debt_q[r] != '0 && (!sched_pending[r] || debt_q[r] == DebtMax)) begin
            force_vld  = 1'b1;
            force_rank = 1'(r);
         end
      end
   end

   assign defer_req = (ref_e'(ref_type) == RefAb) && sched_pending[ref_rank] &&
                      (debt_q[ref_rank] < DebtMax);
   assign defer_acc = (state_q == StIdle) && !force_vld && ref_req_valid && defer_req;
   assign refab_hs  = (state_q == StRef) && cmd_ready && (job_type_q == RefAb);

   always_comb begin
      for (int r = 0; r < NUM_RANKS; r++) debt_d[r] = debt_q[r];
      if (defer_acc) debt_d[ref_rank] = debt_q[ref_rank] + DebtW'(1);
      if (refab_hs && debt_q[job_rank_q] != '0) begin
         debt_d[job_rank_q] = debt_q[job_rank_q] - DebtW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NUM_RANKS; r++) debt_q[r] <= '0;
      end else begin
         for (int r = 0; r < NUM_RANKS; r++) debt_q[r] <= debt_d[r];
      end
   end
`else
   logic unused_cfg;
   assign unused_cfg = ^{sched_pending, 32'(MAX_POSTPONE)};
   assign force_vld  = 1'b0;
   assign force_rank = 1'b0;
   assign defer_req  = 1'b0;
`endif

   always_comb begin
      state_d       = state_q;
      job_type_d    = job_type_q;
      job_rank_d    = job_rank_q;
      job_bank_d    = job_bank_q;
      job_bg_d      = job_bg_q;
      cnt_ref_d     = cnt_ref_q;
      cnt_fgr_d     = cnt_fgr_q;
      tmr_load      = 1'b0;
      tmr_val       = '0;
      ref_req_ready = 1'b0;
      cmd_valid     = 1'b0;
      cmd_op        = OpPreab;
      cmd_rank      = 1'b0;
      cmd_bank      = '0;
      cmd_bg        = '0;

      unique case (state_q)
         StIdle: begin
            if (force_vld) begin
               job_type_d = RefAb;
               job_rank_d = force_rank;
               job_bank_d = '0;
               job_bg_d   = '0;
               state_d    = StBlock;
            end else begin
               ref_req_ready = 1'b1;
               if (ref_req_valid) begin
                  if (ref_e'(ref_type) == RefFgr) begin
                     cnt_fgr_d = cnt_fgr_q + 32'd1;
                  end else if (!defer_req) begin
                     job_type_d = ref_e'(ref_type);
                     job_rank_d = ref_rank;
                     job_bank_d = ref_bank;
                     job_bg_d   = ref_bg;
                     state_d    = StBlock;
                  end
               end
            end
         end
         StBlock: begin
            state_d = rank_banks_open[job_rank_q] ? StPre : StRef;
         end
         StPre: begin
            cmd_valid = 1'b1;
            cmd_op    = OpPreab;
            cmd_rank  = job_rank_q;
            if (cmd_ready) begin
               tmr_load = 1'b1;
               tmr_val  = TrpLd;
               state_d  = StWaitRp;
            end
         end
         StWaitRp: begin
            if (tmr_expire) state_d = StRef;
         end
         StRef: begin
            cmd_valid = 1'b1;
            cmd_op    = ref_to_op(job_type_q);
            cmd_rank  = job_rank_q;
            if (job_type_q != RefAb) begin
               cmd_bank = job_bank_q;
               cmd_bg   = job_bg_q;
            end
            if (cmd_ready) begin
               cnt_ref_d = cnt_ref_q + 32'd1;
               tmr_load  = 1'b1;
               unique case (job_type_q)
                  RefPb:   tmr_val = TrfcPb;
                  RefSb:   tmr_val = TrfcSb;
                  default: tmr_val = TrfcAb;
               endcase
               state_d = StTrfc;
            end
         end
         StTrfc: begin
            if (tmr_expire) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      block_rank = '0;
      if (state_q != StIdle) block_rank[job_rank_q] = 1'b1;
   end

   assign busy            = (state_q != StIdle);
   assign cnt_ref_issued  = cnt_ref_q;
   assign cnt_fgr_dropped = cnt_fgr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         job_type_q <= RefAb;
         job_rank_q <= 1'b0;
         job_bank_q <= '0;
         job_bg_q   <= '0;
         cnt_ref_q  <= '0;
         cnt_fgr_q  <= '0;
      end else begin
         state_q    <= state_d;
         job_type_q <= job_type_d;
         job_rank_q <= job_rank_d;
         job_bank_q <= job_bank_d;
         job_bg_q   <= job_bg_d;
         cnt_ref_q  <= cnt_ref_d;
         cnt_fgr_q  <= cnt_fgr_d;
      end
   end

   ddr5_ref_timer #(
      .Width (16)
   ) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .expire_o   (tmr_expire)
   );

endmodule

// File: tb/tb_ddr5_refresh_executor.sv
// Directed bench for ddr5_refresh_executor. Inputs change and outputs are
// sampled on the falling edge; each sample reflects the state of one cycle.
module tb_ddr5_refresh_executor;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ref_req_valid;
   logic        ref_req_ready;
   logic [1:0]  ref_type;
   logic [4:0]  ref_bank;
   logic [2:0]  ref_bg;
   logic        ref_rank;
   logic [1:0]  rank_banks_open;
   logic [1:0]  sched_pending;
   logic [1:0]  block_rank;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic        cmd_rank;
   logic [4:0]  cmd_bank;
   logic [2:0]  cmd_bg;
   logic        busy;
   logic [31:0] cnt_ref_issued;
   logic [31:0] cnt_fgr_dropped;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ddr5_refresh_executor dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .ref_req_valid   (ref_req_valid),
      .ref_req_ready   (ref_req_ready),
      .ref_type        (ref_type),
      .ref_bank        (ref_bank),
      .ref_bg          (ref_bg),
      .ref_rank        (ref_rank),
      .rank_banks_open (rank_banks_open),
      .sched_pending   (sched_pending),
      .block_rank      (block_rank),
      .cmd_valid       (cmd_valid),
      .cmd_ready       (cmd_ready),
      .cmd_op          (cmd_op),
      .cmd_rank        (cmd_rank),
      .cmd_bank        (cmd_bank),
      .cmd_bg          (cmd_bg),
      .busy            (busy),
      .cnt_ref_issued  (cnt_ref_issued),
      .cnt_fgr_dropped (cnt_fgr_dropped)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // Cycles until ref_req_ready returns, and how many of them had a rank blocked.
   task automatic wait_ready(output int n, output int nb);
      n = 0;
      nb = 0;
      do begin
         step();
         n++;
         if (block_rank != 2'b00) nb++;
      end while (!ref_req_ready && n < 2000);
   endtask

   task automatic wait_cmd(output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!cmd_valid && n < 2000);
   endtask

   task automatic send(input logic [1:0] t, input logic r, input logic [4:0] b,
                       input logic [2:0] g);
      ref_req_valid = 1'b1;
      ref_type      = t;
      ref_rank      = r;
      ref_bank      = b;
      ref_bg        = g;
      check_eq("req_ready", 32'(ref_req_ready), 32'd1);
      step();
      ref_req_valid = 1'b0;
   endtask

   int n, nb;

   initial begin
      rst_n = 1'b0;
      ref_req_valid = 1'b0;
      ref_type = 2'd0;
      ref_bank = '0;
      ref_bg = '0;
      ref_rank = 1'b0;
      rank_banks_open = 2'b00;
      sched_pending = 2'b00;
      cmd_ready = 1'b1;
      step();
      step();
      check_eq("rst_block", 32'(block_rank), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_cmd_valid", 32'(cmd_valid), 32'd0);
      check_eq("rst_cnt_ref", cnt_ref_issued, 32'd0);
      check_eq("rst_cnt_fgr", cnt_fgr_dropped, 32'd0);
      rst_n = 1'b1;
      step();

      // REFab rank0, banks closed: BLOCK at T+1, REFab at T+2.
      send(2'd0, 1'b0, 5'd0, 3'd0);
      check_eq("ab_block_state", 32'(busy), 32'd1);
      check_eq("ab_block_rank", 32'(block_rank), 32'd1);
      check_eq("ab_block_noval", 32'(cmd_valid), 32'd0);
      step();
      check_eq("ab_cmd_valid", 32'(cmd_valid), 32'd1);
      check_eq("ab_cmd_op", 32'(cmd_op), 32'd1);
      check_eq("ab_cmd_rank", 32'(cmd_rank), 32'd0);
      wait_ready(n, nb);
      check_eq("ab_trfc_len", 32'(n), 32'd350);
      check_eq("ab_block_len", 32'(nb), 32'd349);
      check_eq("ab_cnt_ref", cnt_ref_issued, 32'd1);

      // REFpb bank5 bg2 rank1, banks open: PREab, tRP, REFpb.
      rank_banks_open = 2'b10;
      send(2'd1, 1'b1, 5'd5, 3'd2);
      step();
      check_eq("pb_pre_valid", 32'(cmd_valid), 32'd1);
      check_eq("pb_pre_op", 32'(cmd_op), 32'd0);
      check_eq("pb_pre_rank", 32'(cmd_rank), 32'd1);
      check_eq("pb_block_rank", 32'(block_rank), 32'd2);
      wait_cmd(n);
      check_eq("pb_trp_gap", 32'(n), 32'd30);
      check_eq("pb_ref_op", 32'(cmd_op), 32'd2);
      check_eq("pb_ref_bank", 32'(cmd_bank), 32'd5);
      check_eq("pb_ref_bg", 32'(cmd_bg), 32'd2);
      check_eq("pb_ref_rank", 32'(cmd_rank), 32'd1);
      wait_ready(n, nb);
      check_eq("pb_trfc_len", 32'(n), 32'd160);
      check_eq("pb_block_len", 32'(nb), 32'd159);
      rank_banks_open = 2'b00;

      // REFsb with cmd_ready low for 5 cycles: command must hold steady.
      cmd_ready = 1'b0;
      send(2'd2, 1'b0, 5'd3, 3'd1);
      step();
      for (int i = 0; i < 5; i++) begin
         check_eq("sb_hold_valid", 32'(cmd_valid), 32'd1);
         check_eq("sb_hold_op", 32'(cmd_op), 32'd3);
         check_eq("sb_hold_bank", 32'(cmd_bank), 32'd3);
         check_eq("sb_hold_bg", 32'(cmd_bg), 32'd1);
         check_eq("sb_hold_rank", 32'(cmd_rank), 32'd0);
         step();
      end
      check_eq("sb_6th_valid", 32'(cmd_valid), 32'd1);
      cmd_ready = 1'b1;
      wait_ready(n, nb);
      check_eq("sb_trfc_len", 32'(n), 32'd120);
      check_eq("sb_cnt_ref", cnt_ref_issued, 32'd3);

      // FGR tick: consumed in one cycle, no command.
      send(2'd3, 1'b0, 5'd0, 3'd0);
      check_eq("fgr_busy", 32'(busy), 32'd0);
      check_eq("fgr_cmd_valid", 32'(cmd_valid), 32'd0);
      check_eq("fgr_ready", 32'(ref_req_ready), 32'd1);
      check_eq("fgr_cnt", cnt_fgr_dropped, 32'd1);
      check_eq("fgr_cnt_ref", cnt_ref_issued, 32'd3);

`ifdef DDR5_REF_POSTPONE_EN
      // Four postponed REFab on rank1, then a forced one, then drain.
      sched_pending = 2'b10;
      for (int i = 0; i < 4; i++) begin
         send(2'd0, 1'b1, 5'd0, 3'd0);
         check_eq("pp_no_cmd", 32'(cmd_valid), 32'd0);
      end
      ref_req_valid = 1'b1;
      check_eq("pp_force_ready", 32'(ref_req_ready), 32'd0);
      check_eq("pp_force_idle", 32'(busy), 32'd0);
      step();
      step();
      check_eq("pp_force_valid", 32'(cmd_valid), 32'd1);
      check_eq("pp_force_op", 32'(cmd_op), 32'd1);
      check_eq("pp_force_rank", 32'(cmd_rank), 32'd1);
      wait_ready(n, nb);
      check_eq("pp_force_len", 32'(n), 32'd350);
      step();
      ref_req_valid = 1'b0;
      check_eq("pp_5th_taken", 32'(ref_req_ready), 32'd0);
      sched_pending = 2'b00;
      n = 0;
      while (!(ref_req_ready && cnt_ref_issued == 32'd8) && n < 3000) begin
         step();
         n++;
      end
      check_eq("pp_drain_cnt", cnt_ref_issued, 32'd8);
      check_eq("pp_drain_time", 32'(n < 4 * 352 + 4), 32'd1);
`endif

      // Reset during tRFC clears everything at once.
      send(2'd0, 1'b1, 5'd0, 3'd0);
      for (int i = 0; i < 12; i++) step();
      check_eq("rst_mid_busy_pre", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check_eq("rst_mid_block", 32'(block_rank), 32'd0);
      check_eq("rst_mid_busy", 32'(busy), 32'd0);
      check_eq("rst_mid_valid", 32'(cmd_valid), 32'd0);
      check_eq("rst_mid_cnt", cnt_ref_issued, 32'd0);
      step();
      rst_n = 1'b1;
      step();
      send(2'd0, 1'b0, 5'd0, 3'd0);
      check_eq("post_rst_busy", 32'(busy), 32'd1);
      check_eq("post_rst_block", 32'(block_rank), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
